// File: rtl/quad_sum_pkg.sv
// Shared definitions for the four-operand adder: result width helper and
// the set of pipeline depths the adder knows how to build.
package quad_sum_pkg;

    localparam int PIPE_SHORT = 1;
    localparam int PIPE_LONG  = 2;

    // Four w-bit operands summed together need two extra bits of headroom.
    function automatic int sum_width(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/add2_ext.sv
// Two-input unsigned adder whose result is one bit wider than its operands,
// so the carry out is always kept and the sum can never wrap.
module add2_ext #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic [W:0]   o_sum
);

    // Zero-extend both operands before adding so the carry lands in the top bit.
    assign o_sum = {1'b0, i_x} + {1'b0, i_y};

endmodule

// File: rtl/quad_sum_reg.sv
// Four-operand unsigned adder built as a two-level tree of add2_ext blocks.
// The final sum is always registered. With the longer pipeline the
// first-level partial sums are registered too, which adds one cycle of
// latency but keeps a full result every cycle.
module quad_sum_reg
    import quad_sum_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PIPE  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    input  logic [WIDTH-1:0]                c,
    input  logic [WIDTH-1:0]                d,
    output logic [sum_width(WIDTH)-1:0]     sum
);

    localparam int SW = sum_width(WIDTH);

    // Refuse to build with an operand width or pipeline depth this
    // adder does not support.
    if (WIDTH < 1 || WIDTH > 32 || (PIPE != PIPE_SHORT && PIPE != PIPE_LONG)) begin : g_badParams
        $fatal(1, "quad_sum_reg: illegal parameters WIDTH=%0d PIPE=%0d", WIDTH, PIPE);
    end

    logic [WIDTH:0]  w_partialSum0;
    logic [WIDTH:0]  w_partialSum1;
    logic [WIDTH:0]  w_levelTwoA;
    logic [WIDTH:0]  w_levelTwoB;
    logic [SW-1:0]   w_total;
    logic [SW-1:0]   r_sum;

    add2_ext #(.W(WIDTH)) u_addAB (
        .i_x   (a),
        .i_y   (b),
        .o_sum (w_partialSum0)
    );

    add2_ext #(.W(WIDTH)) u_addCD (
        .i_x   (c),
        .i_y   (d),
        .o_sum (w_partialSum1)
    );

    if (PIPE == PIPE_LONG) begin : g_pipeLong
        logic [WIDTH:0] r_partialSum0;
        logic [WIDTH:0] r_partialSum1;

        // Capture the first-level partial sums so the second-level adder
        // works on values from the previous cycle; reset clears them so no
        // stale operands survive into the output after a reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_partialSum0 <= '0;
                r_partialSum1 <= '0;
            end else begin
                r_partialSum0 <= w_partialSum0;
                r_partialSum1 <= w_partialSum1;
            end
        end

        assign w_levelTwoA = r_partialSum0;
        assign w_levelTwoB = r_partialSum1;
    end else begin : g_pipeShort
        assign w_levelTwoA = w_partialSum0;
        assign w_levelTwoB = w_partialSum1;
    end

    add2_ext #(.W(WIDTH + 1)) u_addLevelTwo (
        .i_x   (w_levelTwoA),
        .i_y   (w_levelTwoB),
        .o_sum (w_total)
    );

    // Register the full-precision total so the output is driven purely
    // from a flop; reset forces a clean zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_total;
        end
    end

    assign sum = r_sum;

endmodule

// File: tb/tb_quad_sum_reg.sv
// Self-checking bench for quad_sum_reg. Four instances cover both operand
// widths and both pipeline depths; a history of sampled operand totals and
// reset flags gives the expected output of each instance after every edge.
module tb_quad_sum_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b, c, d;
    logic [7:0] a8, b8, c8, d8;
    logic [5:0] sumW4P1, sumW4P2;
    logic [9:0] sumW8P1, sumW8P2;

    int checkCount = 0;
    int errorCount = 0;

    bit histRst[$];
    int histSum4[$];
    int histSum8[$];

    always #5 clk = ~clk;

    quad_sum_reg #(.WIDTH(4), .PIPE(1)) u_dutW4P1 (
        .clk (clk), .rst (rst), .a (a), .b (b), .c (c), .d (d), .sum (sumW4P1)
    );

    quad_sum_reg #(.WIDTH(4), .PIPE(2)) u_dutW4P2 (
        .clk (clk), .rst (rst), .a (a), .b (b), .c (c), .d (d), .sum (sumW4P2)
    );

    quad_sum_reg #(.WIDTH(8), .PIPE(1)) u_dutW8P1 (
        .clk (clk), .rst (rst), .a (a8), .b (b8), .c (c8), .d (d8), .sum (sumW8P1)
    );

    quad_sum_reg #(.WIDTH(8), .PIPE(2)) u_dutW8P2 (
        .clk (clk), .rst (rst), .a (a8), .b (b8), .c (c8), .d (d8), .sum (sumW8P2)
    );

    // Compare one observed value against its expectation and log a mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // The output after an edge is the total sampled pipe-1 edges earlier,
    // unless reset was high on any of the last pipe edges, in which case it
    // is zero.
    function automatic int modelSum(input int pipe, input bit wide);
        int n;
        n = histRst.size();
        if (n < pipe) return 0;
        for (int i = 0; i < pipe; i++) begin
            if (histRst[n - 1 - i]) return 0;
        end
        return wide ? histSum8[n - pipe] : histSum4[n - pipe];
    endfunction

    // Drive one cycle of operands, record what was sampled, and check every
    // instance against the history model just after the edge.
    task automatic applyStimulus(input bit rstVal,
                                 input int av, input int bv, input int cv, input int dv,
                                 input int a8v, input int b8v, input int c8v, input int d8v);
        @(negedge clk);
        rst = rstVal;
        a   = av[3:0];
        b   = bv[3:0];
        c   = cv[3:0];
        d   = dv[3:0];
        a8  = a8v[7:0];
        b8  = b8v[7:0];
        c8  = c8v[7:0];
        d8  = d8v[7:0];
        @(posedge clk);
        histRst.push_back(rstVal);
        histSum4.push_back(int'(a) + int'(b) + int'(c) + int'(d));
        histSum8.push_back(int'(a8) + int'(b8) + int'(c8) + int'(d8));
        #1;
        checkOutput("w4p1", int'(sumW4P1), modelSum(1, 1'b0));
        checkOutput("w4p2", int'(sumW4P2), modelSum(2, 1'b0));
        checkOutput("w8p1", int'(sumW8P1), modelSum(1, 1'b1));
        checkOutput("w8p2", int'(sumW8P2), modelSum(2, 1'b1));
    endtask

    initial begin
        rst = 1'b1;
        a = '0; b = '0; c = '0; d = '0;
        a8 = '0; b8 = '0; c8 = '0; d8 = '0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 15, 15, 15, 15, 255, 255, 255, 255);
            checkOutput("resetHoldP1", int'(sumW4P1), 0);
            checkOutput("resetHoldP2", int'(sumW4P2), 0);
        end

        applyStimulus(1'b0, 15, 15, 15, 15, 255, 255, 255, 255);
        checkOutput("releaseP1", int'(sumW4P1), 60);
        checkOutput("releaseP2NotYet", int'(sumW4P2), 0);
        checkOutput("releaseW8P1", int'(sumW8P1), 1020);

        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("zeroP1", int'(sumW4P1), 0);
        checkOutput("releaseP2", int'(sumW4P2), 60);

        applyStimulus(1'b0, 1, 2, 3, 4, 1, 2, 3, 4);
        checkOutput("mixedP1", int'(sumW4P1), 10);

        applyStimulus(1'b0, 15, 15, 15, 15, 15, 15, 15, 15);
        checkOutput("maxP1", int'(sumW4P1), 60);

        applyStimulus(1'b0, 15, 0, 0, 1, 15, 0, 0, 1);
        checkOutput("backToBackP1", int'(sumW4P1), 16);
        checkOutput("backToBackP2", int'(sumW4P2), 60);

        applyStimulus(1'b0, 9, 7, 5, 3, 9, 7, 5, 3);
        checkOutput("latencyP1", int'(sumW4P1), 24);
        checkOutput("latencyHoldP2", int'(sumW4P2), 16);

        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("latencyP2", int'(sumW4P2), 24);

        applyStimulus(1'b0, 15, 15, 15, 15, 200, 200, 200, 200);
        applyStimulus(1'b1, 15, 15, 15, 15, 200, 200, 200, 200);
        checkOutput("midResetP2", int'(sumW4P2), 0);
        checkOutput("midResetW8P2", int'(sumW8P2), 0);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flushedP2", int'(sumW4P2), 0);
        checkOutput("flushedW8P2", int'(sumW8P2), 0);

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
